// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: single-cycle 32x32 multiply, 32-cycle restoring divide.
// Optional MDU_DIV_ZERO_FAST_EN: divide by zero bypasses the iteration and completes in one cycle.
module mdu_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] new_hi_o,
    output logic [31:0] new_lo_o,
    output logic        w_hi_o,
    output logic        w_lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_signed;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_in_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_shift;
    logic        w_rem_ge;
    logic [31:0] w_rem_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    assign w_accept    = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_in_signed = ~op_i[0];
    assign w_mag_a     = (w_in_signed && src_a_i[31]) ? (32'd0 - src_a_i) : src_a_i;
    assign w_mag_b     = (w_in_signed && src_b_i[31]) ? (32'd0 - src_b_i) : src_b_i;

    // Sign-extending both operands to 64 bits makes one unsigned multiplier serve both modes.
    assign w_prod = {{32{r_signed & r_a[31]}}, r_a} * {{32{r_signed & r_b[31]}}, r_b};

    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_diff  = w_rem_shift[31:0] - r_dvs;
    assign w_rem_next  = w_rem_ge ? w_rem_diff : w_rem_shift[31:0];
    assign w_quo_next  = {r_quo[30:0], w_rem_ge};

    assign w_neg_q  = r_signed && (r_a[31] ^ r_b[31]);
    assign w_neg_r  = r_signed && r_a[31];
    // A zero divisor reports the raw dividend and an all-ones quotient, without sign fixup.
    assign w_div_hi = (r_b == 32'd0) ? r_a :
                      (w_neg_r ? (32'd0 - w_rem_next) : w_rem_next);
    assign w_div_lo = (r_b == 32'd0) ? 32'hFFFF_FFFF :
                      (w_neg_q ? (32'd0 - w_quo_next) : w_quo_next);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (op_i[1]) begin
`ifdef MDU_DIV_ZERO_FAST_EN
                            w_state_next = (src_b_i == 32'd0) ? S_DONE : S_DIV;
`else
                            w_state_next = S_DIV;
`endif
                        end else begin
                            w_state_next = S_MUL;
                        end
                    end
                end
                S_MUL:   w_state_next = S_DONE;
                S_DIV:   w_state_next = (r_cnt == 6'd31) ? S_DONE : S_DIV;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_signed <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_cnt    <= 6'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (w_accept) begin
            r_signed <= w_in_signed;
            r_a      <= src_a_i;
            r_b      <= src_b_i;
            r_rem    <= 32'd0;
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_cnt    <= 6'd0;
`ifdef MDU_DIV_ZERO_FAST_EN
            if (op_i[1] && (src_b_i == 32'd0)) begin
                r_hi <= src_a_i;
                r_lo <= 32'hFFFF_FFFF;
            end
`endif
        end else if (!flush_i) begin
            if (r_state == S_MUL) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
                if (r_cnt == 6'd31) begin
                    r_hi <= w_div_hi;
                    r_lo <= w_div_lo;
                end
            end
        end
    end

    assign busy_o   = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_hi_o   = (r_state == S_DONE) && !flush_i;
    assign w_lo_o   = (r_state == S_DONE) && !flush_i;
    assign new_hi_o = r_hi;
    assign new_lo_o = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed and random operations against an arithmetic reference.
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] nhi;
    logic [31:0] nlo;
    logic        whi;
    logic        wlo;

    int errors = 0;
    int checks = 0;

    mdu_iter dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .src_a_i  (a),
        .src_b_i  (b),
        .flush_i  (flush),
        .busy_o   (busy),
        .new_hi_o (nhi),
        .new_lo_o (nlo),
        .w_hi_o   (whi),
        .w_lo_o   (wlo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the hardware.
    task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'd0, x} * {32'd0, y};
            default: p = 64'd0;
        endcase
        if (!o[1]) begin
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
        end else begin
            if (!o[0]) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = longint'({32'd0, x}) / longint'({32'd0, y});
                r = longint'({32'd0, x}) % longint'({32'd0, y});
            end
            p  = 64'(q);
            el = p[31:0];
            p  = 64'(r);
            eh = p[31:0];
        end
    endtask

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        int lat;
        lat = o[1] ? 33 : 2;
`ifdef MDU_DIV_ZERO_FAST_EN
        if (o[1] && (y == 32'd0)) lat = 1;
`else
        if (y == 32'hDEAD_BEEF) lat = lat + 0;
`endif
        return lat;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el, gh, gl;
        int lat, first, cnt;
        logic busy1;
        ref_model(o, x, y, eh, el);
        lat   = exp_latency(o, y);
        first = -1;
        cnt   = 0;
        gh    = 32'd0;
        gl    = 32'd0;
        busy1 = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        for (int i = 1; i <= lat + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                busy1 = busy;
            end
            if (whi !== wlo) begin
                errors++;
                $display("FAIL strobe_pair cycle %0d: w_hi=%b w_lo=%b, expected equal", i, whi, wlo);
            end
            if (whi === 1'b1) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    gh = nhi;
                    gl = nlo;
                end
            end
        end
        checks += 5;
        if (first !== lat) begin
            errors++;
            $display("FAIL latency op=%0d a=%h b=%h: got T+%0d, expected T+%0d", o, x, y, first, lat);
        end
        if (cnt !== 1) begin
            errors++;
            $display("FAIL strobe_count op=%0d: got %0d, expected 1", o, cnt);
        end
        if (gh !== eh) begin
            errors++;
            $display("FAIL hi op=%0d a=%h b=%h: got %h, expected %h", o, x, y, gh, eh);
        end
        if (gl !== el) begin
            errors++;
            $display("FAIL lo op=%0d a=%h b=%h: got %h, expected %h", o, x, y, gl, el);
        end
        if (busy1 !== (lat > 1)) begin
            errors++;
            $display("FAIL busy op=%0d: got %b, expected %b", o, busy1, (lat > 1));
        end
        $display("txn op=%0d a=%h b=%h hi=%h lo=%h strobe=T+%0d", o, x, y, gh, gl, first);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
        #12;
        checks++;
        if ({busy, whi, wlo, nhi, nlo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b whi=%b wlo=%b hi=%h lo=%h, expected all 0",
                     busy, whi, wlo, nhi, nlo);
        end
        $display("txn reset busy=%b hi=%h lo=%h", busy, nhi, nlo);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'd3, 32'h0000_0007, 32'h0000_0002);
        run_op(2'd3, 32'h1234_5678, 32'h0000_0000);
        run_op(2'd2, 32'h8765_4321, 32'h0000_0000);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            run_op(o, x, y);
        end
    endtask

    task automatic test_back_to_back();
        logic s [1:7];
        logic [31:0] h2, l2, h5, l5;
        logic busy3;
        h2 = 32'd0; l2 = 32'd0; h5 = 32'd0; l5 = 32'd0; busy3 = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd7;
        @(posedge clk);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op = 2'd1; a = 32'hFFFF_FFFF; b = 32'd2;
            end
            if (i == 3) busy3 = busy;
            if (i == 4) start = 1'b0;
            s[i] = whi;
            if (i == 2) begin h2 = nhi; l2 = nlo; end
            if (i == 5) begin h5 = nhi; l5 = nlo; end
        end
        checks += 4;
        if ({s[1], s[2], s[3], s[4], s[5], s[6], s[7]} !== 7'b0100100) begin
            errors++;
            $display("FAIL b2b_strobes: got %b%b%b%b%b%b%b, expected 0100100",
                     s[1], s[2], s[3], s[4], s[5], s[6], s[7]);
        end
        if ({h2, l2} !== {32'd0, 32'd35}) begin
            errors++;
            $display("FAIL b2b_first: got %h_%h, expected 00000000_00000023", h2, l2);
        end
        if ({h5, l5} !== {32'd1, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL b2b_second: got %h_%h, expected 00000001_fffffffe", h5, l5);
        end
        if (busy3 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b, expected 0", busy3);
        end
        $display("txn back_to_back first=%h_%h second=%h_%h", h2, l2, h5, l5);
    endtask

    task automatic test_flush_div();
        logic [31:0] held_lo;
        logic busy10, busy11, early;
        int first;
        logic [31:0] gl;
        held_lo = nlo; busy10 = 1'b0; busy11 = 1'b1; early = 1'b0; first = -1; gl = 32'd0;
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 10) begin busy10 = busy; flush = 1'b1; end
            if (i == 11) begin
                flush = 1'b0; busy11 = busy;
                if (nlo !== held_lo) early = 1'b1;
                start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
            end
            if (i == 12) start = 1'b0;
            if (whi === 1'b1 && first < 0) begin first = i; gl = nlo; end
        end
        checks += 5;
        if (busy10 !== 1'b1) begin
            errors++;
            $display("FAIL flush_div_busy: got %b, expected 1", busy10);
        end
        if (busy11 !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_idle: busy=%b, expected 0", busy11);
        end
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_hold: lo changed, expected %h held", held_lo);
        end
        if (first !== 13) begin
            errors++;
            $display("FAIL flush_div_restart: strobe at T+%0d, expected T+13", first);
        end
        if (gl !== 32'd12) begin
            errors++;
            $display("FAIL flush_div_result: lo=%h, expected 0000000c", gl);
        end
        $display("txn flush_div restart_strobe=T+%0d lo=%h", first, gl);
    endtask

    task automatic test_flush_done();
        logic pre, gated, later;
        pre = 1'b0; gated = 1'b1; later = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pre = whi;
        flush = 1'b1;
        #1;
        gated = whi | wlo;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush = 1'b0;
            if (whi === 1'b1 || busy === 1'b1) later = 1'b1;
        end
        checks += 3;
        if (pre !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_pre: strobe=%b, expected 1", pre);
        end
        if (gated !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_gate: strobe=%b, expected 0", gated);
        end
        if (later !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_after: activity=%b, expected 0", later);
        end
        $display("txn flush_done gated=%b", gated);
    endtask

    task automatic test_flush_start_idle();
        logic act;
        act = 1'b0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            if (busy === 1'b1 || whi === 1'b1) act = 1'b1;
        end
        checks++;
        if (act !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_idle: activity=%b, expected 0", act);
        end
        $display("txn flush_start_idle activity=%b", act);
    endtask

    task automatic test_reset_mid();
        logic [66:0] snap;
        logic act;
        snap = '1; act = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        snap = {busy, whi, wlo, nhi, nlo};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 8; i <= 40; i++) begin
            @(negedge clk);
            if (whi === 1'b1 || busy === 1'b1) act = 1'b1;
        end
        checks += 2;
        if (snap !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, expected 0", snap);
        end
        if (act !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_strobe: activity=%b, expected 0", act);
        end
        $display("txn reset_mid outputs=%h", snap);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_div();
        test_flush_done();
        test_flush_start_idle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
